// File: rtl/mole_sequencer.sv
// Whack-a-mole game sequencer: GAP -> SHOW -> GRACE rounds driven by an 8-bit LFSR, scoring validator hits.
// Latency: all outputs registered, one cycle after the sampled inputs; no backpressure, start/hit are sampled levels.
module mole_sequencer #(
    parameter int unsigned WINDOW_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES    = 25_000_000,
    parameter int unsigned ROUNDS        = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    output logic [2:0] selector,
    output logic       mole_active,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [7:0] round_cnt,
    output logic       game_over
);

    localparam int unsigned TW = 32;
    localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW_CYCLES - 1);
    localparam logic [7:0]    ROUNDS_8    = 8'(ROUNDS);
    localparam logic [2:0]    SEL_NONE    = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SHOW,
        S_GRACE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [7:0]  lfsr, lfsr_nxt;
    logic [2:0]  selector_nxt;
    logic        mole_active_nxt;
    logic [7:0]  score_nxt, misses_nxt, round_cnt_nxt;
    logic        game_over_nxt;
    logic        hit_q;

    logic        hit_rise;
    logic        lfsr_fb;
    logic [7:0]  lfsr_step;
    logic [2:0]  mole_idx;
    logic        round_end;
    logic        round_hit;
    logic [7:0]  round_inc;

    assign hit_rise  = hit & ~hit_q;
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lfsr_step = {lfsr[6:0], lfsr_fb};
    // Fold 5..7 back onto 0..2 so every LFSR value maps to one of five moles.
    assign mole_idx  = (lfsr_step[2:0] <= 3'd4) ? lfsr_step[2:0] : (lfsr_step[2:0] - 3'd5);
    assign round_inc = round_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            lfsr        <= LFSR_SEED;
            selector    <= SEL_NONE;
            mole_active <= 1'b0;
            score       <= 8'd0;
            misses      <= 8'd0;
            round_cnt   <= 8'd0;
            game_over   <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            lfsr        <= lfsr_nxt;
            selector    <= selector_nxt;
            mole_active <= mole_active_nxt;
            score       <= score_nxt;
            misses      <= misses_nxt;
            round_cnt   <= round_cnt_nxt;
            game_over   <= game_over_nxt;
            hit_q       <= hit;
        end
    end

    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        lfsr_nxt        = lfsr;
        selector_nxt    = selector;
        mole_active_nxt = mole_active;
        score_nxt       = score;
        misses_nxt      = misses;
        round_cnt_nxt   = round_cnt;
        game_over_nxt   = game_over;
        round_end       = 1'b0;
        round_hit       = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt       = S_GAP;
                    timer_nxt       = GAP_LOAD;
                    lfsr_nxt        = LFSR_SEED;
                    selector_nxt    = SEL_NONE;
                    mole_active_nxt = 1'b0;
                    score_nxt       = 8'd0;
                    misses_nxt      = 8'd0;
                    round_cnt_nxt   = 8'd0;
                    game_over_nxt   = 1'b0;
                end
            end
            S_GAP: begin
                if (timer == '0) begin
                    state_nxt       = S_SHOW;
                    timer_nxt       = WINDOW_LOAD;
                    lfsr_nxt        = lfsr_step;
                    selector_nxt    = mole_idx;
                    mole_active_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            S_SHOW: begin
                if (hit_rise) begin
                    round_end = 1'b1;
                    round_hit = 1'b1;
                end else if (timer == '0) begin
                    state_nxt       = S_GRACE;
                    mole_active_nxt = 1'b0;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            // One extra cycle with the selector held so a hit the validator registered late still counts.
            S_GRACE: begin
                round_end = 1'b1;
                round_hit = hit_rise;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (round_end) begin
            mole_active_nxt = 1'b0;
            selector_nxt    = SEL_NONE;
            round_cnt_nxt   = round_inc;
            if (round_hit) begin
                if (score != 8'hFF) begin
                    score_nxt = score + 8'd1;
                end
            end else if (misses != 8'hFF) begin
                misses_nxt = misses + 8'd1;
            end
            if (round_inc == ROUNDS_8) begin
                state_nxt     = S_DONE;
                game_over_nxt = 1'b1;
            end else begin
                state_nxt = S_GAP;
                timer_nxt = GAP_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_mole_sequencer.sv
// Directed bench for mole_sequencer with WINDOW=4, GAP=2, ROUNDS=3, seed 8'hA5.
module tb_mole_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       hit;
    logic [2:0] selector;
    logic       mole_active;
    logic [7:0] score;
    logic [7:0] misses;
    logic [7:0] round_cnt;
    logic       game_over;

    int n_tests;
    int n_fail;

    mole_sequencer #(
        .WINDOW_CYCLES(4),
        .GAP_CYCLES   (2),
        .ROUNDS       (3),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hit        (hit),
        .selector   (selector),
        .mole_active(mole_active),
        .score      (score),
        .misses     (misses),
        .round_cnt  (round_cnt),
        .game_over  (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".sel"},   32'(selector),    32'd7);
        chk({tag, ".mole"},  32'(mole_active), 32'd0);
        chk({tag, ".score"}, 32'(score),       32'd0);
        chk({tag, ".miss"},  32'(misses),      32'd0);
        chk({tag, ".round"}, 32'(round_cnt),   32'd0);
        chk({tag, ".over"},  32'(game_over),   32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        start   = 1'b0;
        hit     = 1'b0;

        // Reset and a full game with no hits: moles 2, 0, 2.
        #2 rst = 1'b1;
        #2;
        chk_reset_vals("por");
        step();
        rst = 1'b0;
        step(2);
        chk("idle_hold.sel", 32'(selector), 32'd7);
        start_game();                                  // edge 1
        chk("gap1.sel",  32'(selector),    32'd7);
        chk("gap1.mole", 32'(mole_active), 32'd0);
        step();                                        // edge 2
        chk("gap2.sel",  32'(selector),    32'd7);
        step();                                        // edge 3
        chk("show1.sel",  32'(selector),    32'd2);
        chk("show1.mole", 32'(mole_active), 32'd1);
        step(3);                                       // edge 6
        chk("show4.mole", 32'(mole_active), 32'd1);
        step();                                        // edge 7
        chk("grace.mole", 32'(mole_active), 32'd0);
        chk("grace.sel",  32'(selector),    32'd2);
        step();                                        // edge 8
        chk("r1end.miss",  32'(misses),    32'd1);
        chk("r1end.round", 32'(round_cnt), 32'd1);
        chk("r1end.sel",   32'(selector),  32'd7);
        step(2);                                       // edge 10
        chk("r2show.sel", 32'(selector), 32'd0);
        step(12);                                      // edge 22
        chk("done.miss",  32'(misses),    32'd3);
        chk("done.score", 32'(score),     32'd0);
        chk("done.round", 32'(round_cnt), 32'd3);
        chk("done.over",  32'(game_over), 32'd1);
        chk("done.sel",   32'(selector),  32'd7);
        step(3);
        chk("done_hold.round", 32'(round_cnt), 32'd3);
        chk("done_hold.over",  32'(game_over), 32'd1);

        // Hit in 2nd SHOW cycle of round 1, then in GRACE of round 2.
        reset_dut();
        start_game();                                  // edge 1
        step(3);                                       // edge 4
        hit = 1'b1;
        step();                                        // edge 5
        chk("hit1.score", 32'(score),       32'd1);
        chk("hit1.round", 32'(round_cnt),   32'd1);
        chk("hit1.mole",  32'(mole_active), 32'd0);
        chk("hit1.sel",   32'(selector),    32'd7);
        hit = 1'b0;
        step(6);                                       // edge 11
        chk("r2grace.sel",  32'(selector),    32'd0);
        chk("r2grace.mole", 32'(mole_active), 32'd0);
        hit = 1'b1;
        step();                                        // edge 12
        chk("hit2.score", 32'(score),     32'd2);
        chk("hit2.miss",  32'(misses),    32'd0);
        chk("hit2.round", 32'(round_cnt), 32'd2);
        hit = 1'b0;

        // Hit held high across the round boundary scores only once.
        reset_dut();
        start_game();
        step(3);
        hit = 1'b1;
        step();                                        // edge 5
        chk("held1.score", 32'(score), 32'd1);
        step(7);                                       // edge 12
        chk("held2.score", 32'(score),     32'd1);
        chk("held2.miss",  32'(misses),    32'd1);
        chk("held2.round", 32'(round_cnt), 32'd2);
        hit = 1'b0;

        // Asynchronous reset during SHOW of round 2.
        reset_dut();
        start_game();
        step(9);                                       // edge 10
        chk("pre_rst.sel",  32'(selector),  32'd0);
        chk("pre_rst.miss", 32'(misses),    32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        step();
        rst = 1'b0;
        step(3);
        chk("post_rst_idle.sel", 32'(selector), 32'd7);
        start_game();
        step(2);                                       // edge 3
        chk("restart.sel",   32'(selector),    32'd2);
        chk("restart.mole",  32'(mole_active), 32'd1);

        // start during SHOW is ignored; start in DONE begins a fresh game.
        start = 1'b1;
        step();                                        // edge 4
        start = 1'b0;
        chk("ign_start.sel",   32'(selector),    32'd2);
        chk("ign_start.mole",  32'(mole_active), 32'd1);
        chk("ign_start.round", 32'(round_cnt),   32'd0);
        step(18);                                      // edge 22
        chk("done2.over", 32'(game_over), 32'd1);
        chk("done2.miss", 32'(misses),    32'd3);
        start_game();
        chk("newgame.over",  32'(game_over), 32'd0);
        chk("newgame.miss",  32'(misses),    32'd0);
        chk("newgame.round", 32'(round_cnt), 32'd0);
        chk("newgame.sel",   32'(selector),  32'd7);
        step(2);
        chk("newgame_show.sel", 32'(selector), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_sequencer.md
MOLE_SEQUENCER -- requirements
Module: mole_sequencer

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 50_000_000, meaning the number of cycles a mole stays lit (SHOW state).
REQ-002 SHALL have parameter GAP_CYCLES, default 25_000_000, meaning the number of dark cycles between moles (GAP state).
REQ-003 SHALL have parameter ROUNDS, default 16, meaning the number of moles per game (range 1..255).
REQ-004 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the LFSR value after reset and on start (nonzero).
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port start  input  1  level; begins a game when sampled high in IDLE or DONE.
REQ-008 SHALL have port hit  input  1  registered validator pulse (selected button level, one cycle behind selector).
REQ-009 SHALL have port selector  output  3  current mole index 0..4 to the validator; 3'b111 when no mole is selectable.
REQ-010 SHALL have port mole_active  output  1  high while the mole LED is lit (SHOW only).
REQ-011 SHALL have port score  output  8  moles hit this game, saturating at 255.
REQ-012 SHALL have port misses  output  8  moles timed out this game, saturating at 255.
REQ-013 SHALL have port round_cnt  output  8  rounds completed this game.
REQ-014 SHALL have port game_over  output  1  high in DONE.

Function
REQ-015 SHALL implement states IDLE, GAP, SHOW, GRACE, DONE; all outputs registered.
REQ-016 In IDLE or DONE, start=1 SHALL clear score, misses and round_cnt, reload the LFSR with LFSR_SEED, load the timer with GAP_CYCLES-1 and enter GAP the next cycle.
REQ-017 start SHALL be ignored in GAP, SHOW and GRACE.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles with selector=3'b111 and mole_active=0, then enter SHOW.
REQ-019 On GAP->SHOW the LFSR SHALL step once: fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}.
REQ-020 Mole index SHALL be m = next[2:0] if next[2:0] <= 4, else next[2:0] - 5; m is latched into selector on SHOW entry and held through GRACE.
REQ-021 SHOW SHALL last at most WINDOW_CYCLES cycles with mole_active=1; GRACE SHALL last exactly 1 cycle with mole_active=0 and selector still held, covering the validator's one-cycle latency.
REQ-022 A hit SHALL be a rising edge of hit (hit=1 and previous-cycle hit=0), edge register cleared by reset.
REQ-023 A hit sampled in SHOW or GRACE SHALL increment score, increment round_cnt and leave the state on the next cycle; hits in any other state SHALL be ignored.
REQ-024 If GRACE ends without a hit, misses and round_cnt SHALL each increment by 1.
REQ-025 After a round ends, the next state SHALL be DONE if the new round_cnt equals ROUNDS, else GAP with the timer reloaded.
REQ-026 hit held high across a round boundary SHALL NOT score in the next round until it falls and rises again.
REQ-027 score and misses SHALL saturate at 8'hFF, and no counter SHALL wrap.
REQ-028 DONE SHALL hold score, misses and round_cnt with game_over=1 and selector=3'b111 until start or rst.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, selector=3'b111, mole_active=0, score=0, misses=0, round_cnt=0, game_over=0, LFSR=LFSR_SEED, timer=0 and hit-edge register=0, including mid-game.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until start=1.

Verification (bench parameters WINDOW_CYCLES=4, GAP_CYCLES=2, ROUNDS=3, LFSR_SEED=8'hA5)
REQ-031 Apply rst, then start pulse -> GAP for 2 cycles with selector=7, then SHOW with selector=2 (LFSR 8'h4A) and mole_active=1 for 4 cycles.
REQ-032 No hit for a full game -> rounds use moles 2, 0 (LFSR 8'h95), ...; final misses=3, score=0, round_cnt=3, game_over=1.
REQ-033 Hit rise in the 2nd SHOW cycle of round 1 -> score=1 the next cycle, GAP entered, mole_active=0; hit rise in GRACE of round 2 -> score=2 and misses unchanged.
REQ-034 Hit held high from round 1 into round 2 -> only 1 score; round 2 times out and misses=1.
REQ-035 Assert rst during SHOW of round 2 -> all outputs return to reset values in the same cycle; start then restarts with selector=2 in round 1.
REQ-036 start asserted during SHOW -> ignored; start in DONE -> counters cleared and a new game begins with selector=2.
